// File: rtl/sig16b_dac_tx.sv
// ============================================================================
// Module      : sig16b_dac_tx
// Description : Serialises one DATA_W-bit sample per sampling period to an
//               external DAC over a 3-wire link (sclk, sdata, fsync).
//               A frame starts on the wrap of sampling_cycle_counter to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sig16b_dac_tx #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 16,
  parameter int CNT_W   = 13
) (
  input  logic              clk_operation,
  input  logic              rst,
  input  logic              enable,
  input  logic [CNT_W-1:0]  sampling_cycle_counter,
  input  logic [DATA_W-1:0] sig16b,
  output logic              sclk,
  output logic              sdata,
  output logic              fsync,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [DIV_W-1:0]  div_cnt, div_cnt_nxt;
  logic              half, half_nxt;
  logic              sclk_nxt, sdata_nxt, fsync_nxt, busy_nxt, done_nxt, overrun_nxt;
  logic              prev_zero;

  logic cnt_zero, strobe, start, div_last, frame_end, accept;

  assign cnt_zero  = (sampling_cycle_counter == '0);
  assign strobe    = cnt_zero && !prev_zero;
  assign start     = strobe && enable;
  assign div_last  = (div_cnt == DIV_LAST);
  // Last edge of the high phase of the final bit.
  assign frame_end = (state == SHIFT) && div_last && sclk && (bit_cnt == BIT_LAST);

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    div_cnt_nxt = div_cnt;
    half_nxt    = half;
    sclk_nxt    = sclk;
    sdata_nxt   = sdata;
    fsync_nxt   = fsync;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    overrun_nxt = overrun;
    accept      = 1'b0;

    case (state)
      IDLE: begin
        accept = start;
      end

      SYNC: begin
        if (start) overrun_nxt = 1'b1;
        div_cnt_nxt = div_cnt + 1'b1;
        if (div_last) begin
          div_cnt_nxt = '0;
          if (!half) begin
            half_nxt = 1'b1;
          end else begin
            // fsync has now been high for two sclk half-periods.
            half_nxt    = 1'b0;
            state_nxt   = SHIFT;
            fsync_nxt   = 1'b0;
            sdata_nxt   = shreg[DATA_W-1];
            bit_cnt_nxt = '0;
          end
        end
      end

      SHIFT: begin
        if (start && !frame_end) overrun_nxt = 1'b1;
        div_cnt_nxt = div_cnt + 1'b1;
        if (div_last) begin
          div_cnt_nxt = '0;
          if (!sclk) begin
            sclk_nxt = 1'b1;
          end else if (bit_cnt != BIT_LAST) begin
            // Falling edge: present the next bit while sclk is low.
            sclk_nxt    = 1'b0;
            shreg_nxt   = {shreg[DATA_W-2:0], 1'b0};
            sdata_nxt   = shreg[DATA_W-2];
            bit_cnt_nxt = bit_cnt + 1'b1;
          end else begin
            sclk_nxt  = 1'b0;
            sdata_nxt = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
            // A start coinciding with the end edge chains frames back to back.
            accept    = start;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (accept) begin
      state_nxt   = SYNC;
      shreg_nxt   = sig16b;
      fsync_nxt   = 1'b1;
      busy_nxt    = 1'b1;
      sclk_nxt    = 1'b0;
      sdata_nxt   = 1'b0;
      div_cnt_nxt = '0;
      half_nxt    = 1'b0;
    end
  end

  // State and output registers; reset aborts any frame immediately.
  always_ff @(posedge clk_operation or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      half      <= 1'b0;
      sclk      <= 1'b0;
      sdata     <= 1'b0;
      fsync     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      prev_zero <= 1'b1;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      bit_cnt   <= bit_cnt_nxt;
      div_cnt   <= div_cnt_nxt;
      half      <= half_nxt;
      sclk      <= sclk_nxt;
      sdata     <= sdata_nxt;
      fsync     <= fsync_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      overrun   <= overrun_nxt;
      prev_zero <= cnt_zero;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sig16b_dac_tx.sv
// ============================================================================
// Module      : tb_sig16b_dac_tx
// Description : Self-checking bench for sig16b_dac_tx. Two instances: default
//               CLK_DIV=4 and CLK_DIV=1. Expected samples are queued when a
//               frame is started and compared against the bits captured on
//               sclk rising edges when done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sig16b_dac_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_a, en_b;
  logic [12:0] cnt_a, cnt_b;
  logic [15:0] sig_a, sig_b;
  logic        sclk_a, sdata_a, fsync_a, busy_a, done_a, overrun_a;
  logic        sclk_b, sdata_b, fsync_b, busy_b, done_b, overrun_b;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] q_a[$];
  logic [15:0] q_b[$];
  int          frames_a = 0;
  int          frames_b = 0;

  always #5 clk = ~clk;

  sig16b_dac_tx dut_a (
    .clk_operation(clk), .rst(rst_n), .enable(en_a),
    .sampling_cycle_counter(cnt_a), .sig16b(sig_a),
    .sclk(sclk_a), .sdata(sdata_a), .fsync(fsync_a),
    .busy(busy_a), .done(done_a), .overrun(overrun_a)
  );

  sig16b_dac_tx #(.CLK_DIV(1)) dut_b (
    .clk_operation(clk), .rst(rst_n), .enable(en_b),
    .sampling_cycle_counter(cnt_b), .sig16b(sig_b),
    .sclk(sclk_b), .sdata(sdata_b), .fsync(fsync_b),
    .busy(busy_b), .done(done_b), .overrun(overrun_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic boundary_a();
    cnt_a = 13'd0;
    tick(1);
    cnt_a = 13'd1;
  endtask

  task automatic wait_done_a(input int bound);
    int n = 0;
    while (!done_a && n < bound) begin
      tick(1);
      n++;
    end
    chk("done_a_seen", {31'd0, done_a}, 32'd1);
  endtask

  // Capture monitor for instance A: sample sdata on each sclk rise.
  logic        ps_a;
  logic [15:0] cap_a, e_a;
  int          nb_a;
  always @(negedge clk) begin
    if (!rst_n) begin
      ps_a = 1'b0; cap_a = '0; nb_a = 0;
    end else begin
      if (sclk_a && !ps_a) begin
        cap_a = {cap_a[14:0], sdata_a};
        nb_a++;
      end
      ps_a = sclk_a;
      if (done_a) begin
        frames_a++;
        chk("sb_a_pending", {31'd0, q_a.size() != 0}, 32'd1);
        if (q_a.size() != 0) begin
          e_a = q_a.pop_front();
          chk("frame_a_data", {16'd0, cap_a}, {16'd0, e_a});
          chk("frame_a_bits", nb_a, 32'd16);
        end
        nb_a = 0;
      end
    end
  end

  // Capture monitor for instance B.
  logic        ps_b;
  logic [15:0] cap_b, e_b;
  int          nb_b;
  always @(negedge clk) begin
    if (!rst_n) begin
      ps_b = 1'b0; cap_b = '0; nb_b = 0;
    end else begin
      if (sclk_b && !ps_b) begin
        cap_b = {cap_b[14:0], sdata_b};
        nb_b++;
      end
      ps_b = sclk_b;
      if (done_b) begin
        frames_b++;
        chk("sb_b_pending", {31'd0, q_b.size() != 0}, 32'd1);
        if (q_b.size() != 0) begin
          e_b = q_b.pop_front();
          chk("frame_b_data", {16'd0, cap_b}, {16'd0, e_b});
          chk("frame_b_bits", nb_b, 32'd16);
        end
        nb_b = 0;
      end
    end
  end

  initial begin
    int f0;
    logic seen;
    rst_n = 1'b0;
    en_a = 1'b1; cnt_a = 13'd5; sig_a = '0;
    en_b = 1'b1; cnt_b = 13'd5; sig_b = '0;

    // Reset state
    tick(5);
    chk("reset_hold_outs", {26'd0, sclk_a, sdata_a, fsync_a, busy_a, done_a, overrun_a}, 32'd0);
    rst_n = 1'b1;
    tick(2);
    chk("reset_rel_outs", {26'd0, sclk_a, sdata_a, fsync_a, busy_a, done_a, overrun_a}, 32'd0);

    // Basic frame 0xA5C3 with timing
    sig_a = 16'hA5C3; q_a.push_back(16'hA5C3);
    boundary_a();
    chk("c0_busy", {31'd0, busy_a}, 32'd1);
    chk("c0_fsync", {31'd0, fsync_a}, 32'd1);
    chk("c0_sclk", {31'd0, sclk_a}, 32'd0);
    tick(7);
    chk("c7_fsync", {31'd0, fsync_a}, 32'd1);
    tick(1);
    chk("c8_fsync", {31'd0, fsync_a}, 32'd0);
    chk("c8_sdata_msb", {31'd0, sdata_a}, 32'd1);
    tick(127);
    chk("c135_busy", {31'd0, busy_a}, 32'd1);
    chk("c135_done", {31'd0, done_a}, 32'd0);
    tick(1);
    chk("c136_done", {31'd0, done_a}, 32'd1);
    chk("c136_busy", {31'd0, busy_a}, 32'd0);
    tick(1);
    chk("c137_done", {31'd0, done_a}, 32'd0);

    // Extreme samples; sample latched at start
    sig_a = 16'h8000; q_a.push_back(16'h8000);
    boundary_a();
    tick(20);
    wait_done_a(200);
    sig_a = 16'h7FFF; q_a.push_back(16'h7FFF);
    boundary_a();
    tick(30);
    sig_a = 16'h1234;
    wait_done_a(200);
    tick(2);

    // Disabled boundary sends nothing
    en_a = 1'b0;
    f0 = frames_a;
    boundary_a();
    seen = 1'b0;
    repeat (150) begin
      tick(1);
      if (sclk_a || fsync_a || busy_a) seen = 1'b1;
    end
    chk("dis_idle", {31'd0, seen}, 32'd0);
    chk("dis_frames", frames_a, f0);
    chk("dis_overrun", {31'd0, overrun_a}, 32'd0);
    en_a = 1'b1;

    // Enable dropped mid-frame: frame completes
    sig_a = 16'h3C5A; q_a.push_back(16'h3C5A);
    boundary_a();
    tick(19);
    en_a = 1'b0;
    wait_done_a(200);
    en_a = 1'b1;
    tick(2);

    // Counter held at zero: one frame only
    f0 = frames_a;
    sig_a = 16'h0F0F; q_a.push_back(16'h0F0F);
    cnt_a = 13'd0;
    tick(3);
    cnt_a = 13'd1;
    wait_done_a(200);
    tick(200);
    chk("hold0_one_frame", frames_a, f0 + 1);

    // Wrap while busy: ignored, overrun sticky
    sig_a = 16'hC001; q_a.push_back(16'hC001);
    boundary_a();
    tick(49);
    cnt_a = 13'd0;
    tick(1);
    cnt_a = 13'd1;
    chk("overrun_set", {31'd0, overrun_a}, 32'd1);
    wait_done_a(200);
    tick(300);
    chk("overrun_sticky", {31'd0, overrun_a}, 32'd1);
    chk("overrun_frames", frames_a, f0 + 2);

    // CLK_DIV=1 back-to-back frames, strobe on the done edge
    sig_b = 16'h1357; q_b.push_back(16'h1357);
    cnt_b = 13'd0;
    tick(1);
    cnt_b = 13'd1;
    tick(33);
    chk("b_c33_done", {31'd0, done_b}, 32'd0);
    sig_b = 16'hBEEF; q_b.push_back(16'hBEEF);
    cnt_b = 13'd0;
    tick(1);
    cnt_b = 13'd1;
    chk("b_c34_done", {31'd0, done_b}, 32'd1);
    chk("b_c34_fsync", {31'd0, fsync_b}, 32'd1);
    chk("b_c34_busy", {31'd0, busy_b}, 32'd1);
    tick(33);
    chk("b_f2_c33_done", {31'd0, done_b}, 32'd0);
    tick(1);
    chk("b_f2_c34_done", {31'd0, done_b}, 32'd1);
    chk("b_f2_c34_fsync", {31'd0, fsync_b}, 32'd0);
    chk("b_overrun", {31'd0, overrun_b}, 32'd0);
    tick(3);
    chk("b_frames", frames_b, 32'd2);

    // Asynchronous reset mid-SHIFT
    sig_a = 16'hFFFF; q_a.push_back(16'hFFFF);
    boundary_a();
    tick(40);
    chk("pre_rst_busy", {31'd0, busy_a}, 32'd1);
    f0 = frames_a;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {26'd0, sclk_a, sdata_a, fsync_a, busy_a, done_a, overrun_a}, 32'd0);
    tick(3);
    chk("rst_no_done", {31'd0, done_a}, 32'd0);
    q_a.delete();
    rst_n = 1'b1;
    tick(200);
    chk("rst_no_resume", frames_a, f0);
    chk("post_rst_outs", {26'd0, sclk_a, sdata_a, fsync_a, busy_a, done_a, overrun_a}, 32'd0);

    chk("sb_a_drained", q_a.size(), 32'd0);
    chk("sb_b_drained", q_b.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
